// File: rtl/adc_ltc2308_ctrl_if.sv
// ---------------------------------------------------------------------------
// adc_ltc2308_ctrl_if
// The four LTC2308 serial-interface pins, bundled into one interface.
//   master : the conversion initiator (drives CONVST/SCK/SDI, reads SDO)
//   slave  : the ADC device side (reads CONVST/SCK/SDI, drives SDO)
// ---------------------------------------------------------------------------
interface adc_ltc2308_ctrl_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (
        output ADC_CONVST,
        output ADC_SCK,
        output ADC_SDI,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CONVST,
        input  ADC_SCK,
        input  ADC_SDI,
        output ADC_SDO
    );
endinterface

// File: rtl/adc_ltc2308_ctrl.sv
// ---------------------------------------------------------------------------
// adc_ltc2308_ctrl
// Initiator for the LTC2308 serial ADC. It starts conversions with CONVST,
// clocks out the result over SCK while shifting the next configuration word
// onto SDI, and presents each 12-bit sample with a one-cycle valid strobe.
//
// Ports
//   i_clk, i_reset : system clock, asynchronous active-high reset
//   i_enable       : run continuous conversions while high
//   i_channel      : channel for the next configuration word
//   i_unipolar     : UNI bit for the next configuration word
//   adc            : ADC pins (CONVST, SCK, SDI out; SDO in)
//   o_data         : last captured sample, unsigned
//   o_valid        : one-cycle strobe, o_data/o_channel updated
//   o_channel      : channel that o_data belongs to
//   o_busy         : high from CONVST rise until the frame ends
// ---------------------------------------------------------------------------
module adc_ltc2308_ctrl #(
    parameter int DATA_WIDTH    = 12,
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 250
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [2:0]            i_channel,
    input  logic                  i_unipolar,
    adc_ltc2308_ctrl_if.master    adc,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [2:0]            o_channel,
    output logic                  o_busy
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int CW = $clog2(CONV_CYCLES) + 1;
    localparam int PW = $clog2(SAMPLE_PERIOD) + 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;

    state_t                state;
    logic [CW-1:0]         conv_cnt;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [PW-1:0]         per_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [2:0]            cfg_ch;
    logic                  cfg_uni;
    logic [2:0]            ch_hist;
    logic                  convst_q;
    logic                  sck_q;
    logic                  sdi_q;
    logic                  start_frame;

    // Configuration word, first bit out first: S/D, O/S, S1, S0, UNI, SLP.
    function automatic logic cfg_bit(input logic [BW-1:0] idx,
                                     input logic [2:0] ch,
                                     input logic uni);
        logic b;
        case (idx)
            BW'(0):  b = 1'b1;
            BW'(1):  b = ch[0];
            BW'(2):  b = ch[2];
            BW'(3):  b = ch[1];
            BW'(4):  b = uni;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // The period counter saturates, so when the frame is longer than the
    // sample period the next conversion starts the first cycle in GAP.
    always_comb begin
        start_frame = 1'b0;
        if (i_enable && (state == IDLE || (state == GAP && per_cnt == PER_LAST)))
            start_frame = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            conv_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            per_cnt   <= '0;
            shreg     <= '0;
            cfg_ch    <= '0;
            cfg_uni   <= 1'b0;
            ch_hist   <= '0;
            convst_q  <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_channel <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (per_cnt != PER_LAST)
                per_cnt <= per_cnt + 1'b1;

            case (state)
                IDLE: ;
                CONV: begin
                    if (conv_cnt == CONV_LAST) begin
                        convst_q <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        sck_q    <= 1'b0;
                        sdi_q    <= cfg_bit('0, cfg_ch, cfg_uni);
                        state    <= SHIFT;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            shreg <= {shreg[DATA_WIDTH-2:0], adc.ADC_SDO};
                        end else if (bit_cnt != LAST_BIT) begin
                            sck_q   <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            sdi_q   <= cfg_bit(bit_cnt + 1'b1, cfg_ch, cfg_uni);
                        end else begin
                            // The ADC applies a configuration to the following
                            // conversion, so this sample belongs to the
                            // channel latched one frame earlier.
                            sck_q     <= 1'b0;
                            sdi_q     <= 1'b0;
                            o_data    <= shreg;
                            o_valid   <= 1'b1;
                            o_busy    <= 1'b0;
                            o_channel <= ch_hist;
                            ch_hist   <= cfg_ch;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (!i_enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (start_frame) begin
                convst_q <= 1'b1;
                o_busy   <= 1'b1;
                conv_cnt <= '0;
                per_cnt  <= '0;
                cfg_ch   <= i_channel;
                cfg_uni  <= i_unipolar;
                state    <= CONV;
            end
        end
    end

    assign adc.ADC_CONVST = convst_q;
    assign adc.ADC_SCK    = sck_q;
    assign adc.ADC_SDI    = sdi_q;

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_ltc2308_ctrl
// Directed bench for adc_ltc2308_ctrl. A default-parameter instance covers
// timing, configuration word, channel tagging, enable drop and reset; a
// second instance with a 50-cycle sample period covers back-to-back frames.
// ---------------------------------------------------------------------------
module tb_adc_ltc2308_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic [2:0]  i_channel = '0;
    logic        i_unipolar = 1'b0;
    logic        enable_s = 1'b0;

    logic [11:0] o_data, o_data_s;
    logic        o_valid, o_valid_s;
    logic [2:0]  o_channel, o_channel_s;
    logic        o_busy, o_busy_s;

    adc_ltc2308_ctrl_if bus ();
    adc_ltc2308_ctrl_if bus_s ();

    adc_ltc2308_ctrl dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_channel(i_channel), .i_unipolar(i_unipolar), .adc(bus),
        .o_data(o_data), .o_valid(o_valid), .o_channel(o_channel), .o_busy(o_busy)
    );

    adc_ltc2308_ctrl #(.SAMPLE_PERIOD(50)) dut_s (
        .i_clk(clk), .i_reset(i_reset), .i_enable(enable_s),
        .i_channel(3'd2), .i_unipolar(1'b0), .adc(bus_s),
        .o_data(o_data_s), .o_valid(o_valid_s), .o_channel(o_channel_s), .o_busy(o_busy_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ADC models: load the sample when CONVST falls, MSB first, next bit
    // presented after each SCK falling edge.
    logic [11:0] adc_val = 12'hA5C;
    logic [11:0] adc_sr = '0;
    logic [11:0] adc_sr_s = '0;
    initial begin
        bus.ADC_SDO = 1'b0;
        bus_s.ADC_SDO = 1'b0;
    end
    always @(negedge bus.ADC_CONVST) begin
        adc_sr = adc_val;
        bus.ADC_SDO = adc_sr[11];
    end
    always @(negedge bus.ADC_SCK) begin
        adc_sr = {adc_sr[10:0], 1'b0};
        bus.ADC_SDO = adc_sr[11];
    end
    always @(negedge bus_s.ADC_CONVST) begin
        adc_sr_s = 12'h5A3;
        bus_s.ADC_SDO = adc_sr_s[11];
    end
    always @(negedge bus_s.ADC_SCK) begin
        adc_sr_s = {adc_sr_s[10:0], 1'b0};
        bus_s.ADC_SDO = adc_sr_s[11];
    end

    // Event recorders, sampled on the falling clock edge.
    int   conv_rise[$], conv_fall[$], sck_rise[$], valid_q[$];
    logic sdi_bits[$];
    logic [11:0] data_q[$];
    logic [2:0]  ch_q[$];
    logic p_conv = 1'b0, p_sck = 1'b0;

    int   convs_rise[$], valid_s[$], sck_at_valid_s[$];
    logic [11:0] data_s[$];
    int   sck_s_cnt = 0;
    logic p_conv_s = 1'b0, p_sck_s = 1'b0;

    always @(negedge clk) begin
        if (bus.ADC_CONVST && !p_conv) conv_rise.push_back(cyc);
        if (!bus.ADC_CONVST && p_conv) conv_fall.push_back(cyc);
        if (bus.ADC_SCK && !p_sck) begin
            sck_rise.push_back(cyc);
            sdi_bits.push_back(bus.ADC_SDI);
        end
        if (o_valid) begin
            valid_q.push_back(cyc);
            data_q.push_back(o_data);
            ch_q.push_back(o_channel);
        end
        p_conv = bus.ADC_CONVST;
        p_sck  = bus.ADC_SCK;

        if (bus_s.ADC_CONVST && !p_conv_s) convs_rise.push_back(cyc);
        if (bus_s.ADC_SCK && !p_sck_s) sck_s_cnt++;
        if (o_valid_s) begin
            valid_s.push_back(cyc);
            data_s.push_back(o_data_s);
            sck_at_valid_s.push_back(sck_s_cnt);
        end
        p_conv_s = bus_s.ADC_CONVST;
        p_sck_s  = bus_s.ADC_SCK;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return conv_rise.size();
            1:       return sck_rise.size();
            2:       return valid_q.size();
            default: return valid_s.size();
        endcase
    endfunction

    // Bounded wait; an expired budget shows up as a failed count check.
    task automatic wait_for(input string tag, input int which, input int n, input int budget);
        int k = 0;
        while (qsize(which) < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(qsize(which)), 32'(n));
    endtask

    task automatic clear_q();
        conv_rise.delete(); conv_fall.delete(); sck_rise.delete();
        valid_q.delete(); sdi_bits.delete(); data_q.delete(); ch_q.delete();
    endtask

    task automatic do_reset();
        i_enable = 1'b0;
        i_reset = 1'b1;
        repeat (3) step();
        clear_q();
        i_reset = 1'b0;
        step();
    endtask

    function automatic logic [11:0] sdi_word();
        logic [11:0] w = '0;
        for (int k = 0; k < 12 && k < sdi_bits.size(); k++)
            w = {w[10:0], sdi_bits[k]};
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_en;

        // Reset state
        repeat (2) step();
        check("rst_convst", 32'(bus.ADC_CONVST), 0);
        check("rst_sck",    32'(bus.ADC_SCK), 0);
        check("rst_sdi",    32'(bus.ADC_SDI), 0);
        check("rst_valid",  32'(o_valid), 0);
        check("rst_busy",   32'(o_busy), 0);
        check("rst_data",   32'(o_data), 0);
        check("rst_chan",   32'(o_channel), 0);
        do_reset();

        // 1: basic frame timing and data
        adc_val = 12'hA5C;
        i_channel = 3'd0; i_unipolar = 1'b0;
        i_enable = 1'b1;
        cyc_en = cyc;
        wait_for("t1_conv_seen", 0, 1, 10);
        check("t1_busy_high", 32'(o_busy), 1);
        wait_for("t1_valid_seen", 2, 1, 400);
        i_enable = 1'b0;
        check("t1_conv_delay", 32'(conv_rise[0] - cyc_en), 1);
        check("t1_conv_width", 32'(conv_fall[0] - conv_rise[0]), 80);
        check("t1_sck_count",  32'(sck_rise.size()), 12);
        check("t1_sck_first",  32'(sck_rise[0] - conv_rise[0]), 82);
        check("t1_sck_span",   32'(sck_rise[11] - sck_rise[0]), 44);
        check("t1_valid_pos",  32'(valid_q[0] - sck_rise[11]), 2);
        check("t1_data",       32'(data_q[0]), 32'h A5C);
        check("t1_chan",       32'(ch_q[0]), 0);
        check("t1_sdi_word",   32'(sdi_word()), 32'h800);
        step();
        check("t1_busy_low",   32'(o_busy), 0);

        // 2: configuration word on SDI
        do_reset();
        i_channel = 3'd5; i_unipolar = 1'b1;
        i_enable = 1'b1;
        wait_for("t2_valid_seen", 2, 1, 400);
        i_enable = 1'b0;
        check("t2_sdi_word", 32'(sdi_word()), 32'hE80);

        // 3: continuous conversions, channel tagging
        do_reset();
        adc_val = 12'h3C7;
        i_channel = 3'd3; i_unipolar = 1'b0;
        i_enable = 1'b1;
        wait_for("t3_conv1", 0, 1, 10);
        i_channel = 3'd6;
        wait_for("t3_conv2", 0, 2, 400);
        i_channel = 3'd1;
        wait_for("t3_valid3", 2, 3, 400);
        i_enable = 1'b0;
        check("t3_period_a", 32'(conv_rise[1] - conv_rise[0]), 250);
        check("t3_period_b", 32'(conv_rise[2] - conv_rise[1]), 250);
        check("t3_vgap_a",   32'(valid_q[1] - valid_q[0]), 250);
        check("t3_vgap_b",   32'(valid_q[2] - valid_q[1]), 250);
        check("t3_chan0",    32'(ch_q[0]), 0);
        check("t3_chan1",    32'(ch_q[1]), 3);
        check("t3_chan2",    32'(ch_q[2]), 6);
        check("t3_data2",    32'(data_q[2]), 32'h3C7);
        repeat (300) step();
        check("t3_conv_stop", 32'(conv_rise.size()), 3);

        // 4: sample period shorter than the frame
        enable_s = 1'b1;
        wait_for("t4_valid3", 3, 3, 600);
        enable_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t4_frame_len", 32'(valid_s[k] - convs_rise[k]), 128);
            check("t4_sck_total", 32'(sck_at_valid_s[k]), 32'(12 * (k + 1)));
            check("t4_data",      32'(data_s[k]), 32'h5A3);
        end
        for (int k = 0; k < 2; k++)
            check("t4_restart", 32'(convs_rise[k + 1] - valid_s[k]), 1);

        // 5: enable dropped during bit 4
        do_reset();
        adc_val = 12'h0F1;
        i_channel = 3'd2;
        i_enable = 1'b1;
        wait_for("t5_bit4", 1, 5, 400);
        i_enable = 1'b0;
        repeat (400) step();
        check("t5_valid_cnt", 32'(valid_q.size()), 1);
        check("t5_sck_cnt",   32'(sck_rise.size()), 12);
        check("t5_conv_cnt",  32'(conv_rise.size()), 1);
        check("t5_data",      32'(o_data), 32'h0F1);
        check("t5_busy",      32'(o_busy), 0);

        // 6: reset in the middle of the second frame
        do_reset();
        adc_val = 12'hA5C;
        i_channel = 3'd4;
        i_enable = 1'b1;
        wait_for("t6_conv1", 0, 1, 10);
        i_channel = 3'd7;
        wait_for("t6_mid_shift", 1, 18, 600);
        check("t6_pre_data", 32'(o_data), 32'hA5C);
        i_reset = 1'b1;
        #1;
        check("t6_convst", 32'(bus.ADC_CONVST), 0);
        check("t6_sck",    32'(bus.ADC_SCK), 0);
        check("t6_sdi",    32'(bus.ADC_SDI), 0);
        check("t6_valid",  32'(o_valid), 0);
        check("t6_busy",   32'(o_busy), 0);
        check("t6_data",   32'(o_data), 0);
        check("t6_chan",   32'(o_channel), 0);
        i_enable = 1'b0;
        repeat (3) step();
        check("t6_no_partial", 32'(valid_q.size()), 1);
        clear_q();
        i_reset = 1'b0;
        step();
        i_channel = 3'd3;
        i_enable = 1'b1;
        wait_for("t6_valid_after", 2, 1, 400);
        i_enable = 1'b0;
        check("t6_first_chan", 32'(ch_q[0]), 0);
        check("t6_first_data", 32'(data_q[0]), 32'hA5C);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ltc2308_ctrl.md
Name: adc_ltc2308_ctrl

Overview:
Initiator side of the LTC2308 serial ADC interface on the DE10-Nano. It drives ADC_CONVST, ADC_SCK and ADC_SDI, and deserialises ADC_SDO into parallel 12-bit samples. Each sample is presented with a one-cycle valid strobe. It sits between the ADC pins and the FIR/CIC/IIR filter inputs, and replaces the direct connection of raw SDO bits to those filters.

Parameters:
DATA_WIDTH, 12, sample width and number of SCK pulses per frame
CLK_DIV, 2, i_clk cycles per SCK half-period (SCK = 12.5 MHz at 50 MHz); legal range >= 1
CONV_CYCLES, 80, i_clk cycles CONVST is held high (1.6 us tCONV at 50 MHz); legal range >= 1
SAMPLE_PERIOD, 250, i_clk cycles between consecutive CONVST rising edges (200 kSPS)

Ports:
i_clk  in  1  system clock, 50 MHz
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  run continuous conversions while high
i_channel  in  3  channel for the next configuration word
i_unipolar  in  1  UNI bit for the next configuration word
ADC_SDO  in  1  serial data from ADC, MSB first
ADC_CONVST  out  1  conversion start
ADC_SCK  out  1  serial clock; idles low
ADC_SDI  out  1  serial configuration data to ADC
o_data  out  DATA_WIDTH  last captured sample, unsigned
o_valid  out  1  one-cycle strobe; o_data and o_channel are new
o_channel  out  3  channel that o_data belongs to
o_busy  out  1  high from CONVST rise until the frame ends

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - all outputs 0; state IDLE; SCK idles low.
  - channel history register cleared to 0.
- All outputs are registered.
- FSM states: IDLE, CONV, SHIFT, GAP.
- IDLE:
  - i_enable sampled high -> next cycle CONVST=1, o_busy=1, enter CONV.
  - i_channel and i_unipolar are latched in the same cycle.
  - Period counter restarts at 0 on every CONVST rise.
- CONV:
  - CONVST held high for exactly CONV_CYCLES cycles, then driven 0.
  - SHIFT starts on the cycle CONVST goes low.
- SHIFT:
  - DATA_WIDTH SCK pulses; each pulse is CLK_DIV cycles low, then CLK_DIV cycles high.
  - SDI changes only at the start of each low phase.
  - SDO is sampled into the shift register MSB-first in the cycle SCK is driven 0->1.
- SDI word for bits 0..5: S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=i_unipolar, SLP=0. Bits 6..11: SDI=0.
- End of frame:
  - On the cycle after the 12th rising SCK: o_data=shift register, o_valid=1 for one cycle, o_busy=0, SCK=0, SDI=0.
  - Enter GAP.
- Channel tagging: the LTC2308 applies the configuration to the following conversion.
  - o_channel = channel latched for the previous frame.
  - The first frame after reset reports 0.
- GAP:
  - When the period counter reaches SAMPLE_PERIOD-1 and i_enable=1 -> CONVST=1 next cycle (CONV).
  - If i_enable=0 -> IDLE.
- Short period: frame length is CONV_CYCLES + 2*CLK_DIV*DATA_WIDTH + 1.
  - If SAMPLE_PERIOD is less than the frame length, the next frame starts on the cycle after o_valid.
  - No frame is ever truncated.
- i_enable deasserted mid-frame: the current frame completes and o_valid fires, then the FSM enters IDLE.
- i_channel/i_unipolar changes mid-frame do not affect the frame in progress.

Test Plan:
1. Reset release, i_enable=1, ADC model returns 0xA5C. Expected:
   - CONVST rises 1 cycle after enable and stays high 80 cycles.
   - 12 SCK pulses of period 4 cycles follow.
   - o_data=0xA5C with o_valid one cycle after the 12th SCK rise.
   - o_channel=0.
2. i_channel=5, i_unipolar=1. Expected: SDI at successive SCK rises = 1,1,1,0,1,0, followed by six 0s.
3. Continuous enable with channels 3, 6, 1 on successive frames. Expected:
   - CONVST rises exactly 250 cycles apart.
   - o_channel = 0, 3, 6.
   - o_valid pulses are exactly 250 cycles apart.
4. SAMPLE_PERIOD=50 (less than the 129-cycle frame). Expected: each CONVST rises the cycle after the previous o_valid; no frame is truncated.
5. i_enable dropped during SHIFT bit 4. Expected: frame finishes, o_valid fires once, FSM goes IDLE, no further CONVST.
6. i_reset asserted mid-SHIFT. Expected:
   - CONVST/SCK/SDI/o_valid/o_busy/o_data go to 0 in the same cycle, with no partial o_valid.
   - After release with enable high, the first frame reports o_channel=0.
